dmem_port_arbiter: RTL

//  Shares the single data-memory port between the two issue lanes (A = older, B = younger)
//  of the dual-issue core. Grants in program order: on a same-cycle collision A goes first and
//  B is held one cycle. Returns load data to the issuing lane and counts stall cycles.

---
 rtl/dmem_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data-memory port between the two issue lanes of the
//   dual-issue core. Lane A is the older instruction, lane B the younger.
//   If both lanes request in the same cycle, A is granted first and B is
//   granted in the following cycle. Load data is returned to the lane that
//   issued the load, and the number of cycles B was held is counted.
//
//   Ports
//     clk, reset          system clock; synchronous active-high reset
//     flush_i             pipeline flush: blocks all grants this cycle
//     req_*_a_i/o         lane A request (valid/ready, addr, wdata, we, re)
//     req_*_b_i/o         lane B request (same set)
//     dmem_*_o            muxed request to data memory (all zero when idle)
//     dmem_rdata_i        memory read data, one cycle after dmem_re_o
//     resp_valid_a/b_o    load data on resp_rdata_o belongs to lane A/B
//     resp_rdata_o        load data (direct pass of dmem_rdata_i)
//     conflict_cnt_o      saturating count of cycles B waited behind A
// ----------------------------------------------------------------------------
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | port free; A has priority, B granted when A is not requesting
// ST_HOLD_B | B lost a collision last cycle and is served now; A is blocked
// ----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int CntWidth = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,

    input  logic                req_valid_a_i,
    output logic                req_ready_a_o,
    input  logic [XLEN-1:0]     req_addr_a_i,
    input  logic [XLEN-1:0]     req_wdata_a_i,
    input  logic [3:0]          req_we_a_i,
    input  logic                req_re_a_i,

    input  logic                req_valid_b_i,
    output logic                req_ready_b_o,
    input  logic [XLEN-1:0]     req_addr_b_i,
    input  logic [XLEN-1:0]     req_wdata_b_i,
    input  logic [3:0]          req_we_b_i,
    input  logic                req_re_b_i,

    output logic [XLEN-1:0]     dmem_addr_o,
    output logic [XLEN-1:0]     dmem_wdata_o,
    output logic [3:0]          dmem_we_o,
    output logic                dmem_re_o,
    input  logic [XLEN-1:0]     dmem_rdata_i,

    output logic                resp_valid_a_o,
    output logic                resp_valid_b_o,
    output logic [XLEN-1:0]     resp_rdata_o,
    output logic [CntWidth-1:0] conflict_cnt_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_HOLD_B = 1'b1;

    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic                grant_a;
    logic                grant_b;
    logic                collide;
    logic                resp_pend_a;
    logic                resp_pend_b;
    logic [CntWidth-1:0] conflict_cnt;

    // Grant decision. Reset and flush both suppress every grant and send the
    // FSM back to idle, which also discards a B request waiting in HOLD_B.
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        collide   = 1'b0;
        state_nxt = ST_IDLE;
        if (!reset && !flush_i) begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_a_i) begin
                        grant_a = 1'b1;
                        if (req_valid_b_i) begin
                            collide   = 1'b1;
                            state_nxt = ST_HOLD_B;
                        end
                    end else if (req_valid_b_i) begin
                        grant_b = 1'b1;
                    end
                end
                ST_HOLD_B: begin
                    // B may have withdrawn; then the cycle simply passes idle.
                    grant_b = req_valid_b_i;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_a_o = grant_a;
    assign req_ready_b_o = grant_b;

    // Port mux. A request carrying any byte enable is a store even if its
    // read enable is also set, so no read is issued and no response follows.
    always_comb begin
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_we_o    = 4'd0;
        dmem_re_o    = 1'b0;
        if (grant_a) begin
            dmem_addr_o  = req_addr_a_i;
            dmem_wdata_o = req_wdata_a_i;
            dmem_we_o    = req_we_a_i;
            dmem_re_o    = req_re_a_i && (req_we_a_i == 4'd0);
        end else if (grant_b) begin
            dmem_addr_o  = req_addr_b_i;
            dmem_wdata_o = req_wdata_b_i;
            dmem_we_o    = req_we_b_i;
            dmem_re_o    = req_re_b_i && (req_we_b_i == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            resp_pend_a  <= 1'b0;
            resp_pend_b  <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state       <= state_nxt;
            resp_pend_a <= grant_a && dmem_re_o;
            resp_pend_b <= grant_b && dmem_re_o;
            if (collide && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CntOne;
            end
        end
    end

    // A response that would land in a reset cycle belongs to a squashed
    // instruction, so it is masked immediately rather than a cycle later.
    assign resp_valid_a_o = resp_pend_a && !reset;
    assign resp_valid_b_o = resp_pend_b && !reset;
    assign resp_rdata_o   = dmem_rdata_i;
    assign conflict_cnt_o = conflict_cnt;

endmodule
